// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared response type and parameter limits for the OBI responder
package cv32e40p_pkg;

  localparam int unsigned RESP_LATENCY_MIN    = 1;
  localparam int unsigned RESP_LATENCY_MAX    = 4;
  localparam int unsigned MAX_OUTSTANDING_MIN = 1;
  localparam int unsigned MAX_OUTSTANDING_MAX = 4;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        we;
  } obi_resp_t;

  // Pull a parameter value into its supported range
  function automatic int unsigned clamp_range(input int unsigned v,
                                              input int unsigned lo,
                                              input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // Only successful reads carry memory data; writes and errors answer with zero
  function automatic obi_resp_t resp_merge(input obi_resp_t e, input logic [31:0] mem_rdata);
    obi_resp_t r;
    r = e;
    if (!e.err && !e.we) r.rdata = mem_rdata;
    return r;
  endfunction

endpackage

// File: rtl/cv32e40p_obi_resp_pipe.sv
// rtl/cv32e40p_obi_resp_pipe.sv - fixed-latency response delay line with read data merge
module cv32e40p_obi_resp_pipe
  import cv32e40p_pkg::*;
#(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  obi_resp_t   push_entry_i,
  input  logic [31:0] mem_rdata_i,
  output logic        valid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  logic [LATENCY-1:0] valid_q;
  obi_resp_t          entry_q    [LATENCY];
  obi_resp_t          stage_view [LATENCY];

  // Stage 1 sees the memory read data, which arrives one cycle after accept
  always_comb begin
    for (int i = 0; i < LATENCY; i++) stage_view[i] = entry_q[i];
    stage_view[0] = resp_merge(entry_q[0], mem_rdata_i);
  end

  // Shift accepted transactions toward the output; reset drops everything in flight
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < LATENCY; i++) entry_q[i] <= '0;
    end else begin
      valid_q[0] <= push_i;
      entry_q[0] <= push_i ? push_entry_i : '0;
      for (int i = 1; i < LATENCY; i++) begin
        valid_q[i] <= valid_q[i-1];
        entry_q[i] <= stage_view[i-1];
      end
    end
  end

  assign valid_o = valid_q[LATENCY-1];
  assign rdata_o = valid_o ? stage_view[LATENCY-1].rdata : 32'h0;
  assign err_o   = valid_o & stage_view[LATENCY-1].err;

endmodule

// File: rtl/cv32e40p_obi_responder.sv
// rtl/cv32e40p_obi_responder.sv - OBI responder bridging to a one-cycle-latency word memory
module cv32e40p_obi_responder
  import cv32e40p_pkg::*;
#(
  parameter int unsigned MEM_WORDS       = 1024,
  parameter int unsigned GNT_WAIT        = 0,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         obi_req_i,
  output logic                         obi_gnt_o,
  input  logic [31:0]                  obi_addr_i,
  input  logic                         obi_we_i,
  input  logic [3:0]                   obi_be_i,
  input  logic [31:0]                  obi_wdata_i,
  output logic                         obi_rvalid_o,
  output logic [31:0]                  obi_rdata_o,
  output logic                         obi_err_o,
  output logic                         mem_req_o,
  output logic                         mem_we_o,
  output logic [$clog2(MEM_WORDS)-1:0] mem_addr_o,
  output logic [3:0]                   mem_be_o,
  output logic [31:0]                  mem_wdata_o,
  input  logic [31:0]                  mem_rdata_i
);

  localparam int unsigned AW      = $clog2(MEM_WORDS);
  localparam int unsigned LAT     = clamp_range(RESP_LATENCY, RESP_LATENCY_MIN, RESP_LATENCY_MAX);
  localparam int unsigned MAX_OUT = clamp_range(MAX_OUTSTANDING, MAX_OUTSTANDING_MIN,
                                                MAX_OUTSTANDING_MAX);
  localparam int unsigned WAIT_W  = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam int unsigned CNT_W   = $clog2(MAX_OUT + 1);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              addr_err;
  logic              wait_done;
  logic              room;
  logic              accept;
  logic              resp_valid;
  obi_resp_t         push_entry;

  assign addr_err  = (obi_addr_i[1:0] != 2'b00) ||
                     ({2'b00, obi_addr_i[31:2]} >= 32'(MEM_WORDS));
  // The wait counter saturates at GNT_WAIT, so equality means the hold time has elapsed
  assign wait_done = (wait_q == WAIT_W'(GNT_WAIT));
  // A full tracker still has room when a response leaves in the same cycle
  assign room      = (cnt_q != CNT_W'(MAX_OUT)) || resp_valid;
  assign obi_gnt_o = obi_req_i && !rst_i && wait_done && room;
  assign accept    = obi_gnt_o;

  assign mem_req_o   = accept && !addr_err;
  assign mem_we_o    = obi_we_i;
  assign mem_addr_o  = obi_addr_i[2 +: AW];
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  assign push_entry = '{rdata: 32'h0, err: addr_err, we: obi_we_i};

  // Next-state for the grant wait counter and the outstanding transaction count
  always_comb begin
    wait_d = wait_q;
    cnt_d  = cnt_q;
    if (!obi_req_i || accept) wait_d = '0;
    else if (!wait_done)      wait_d = wait_q + WAIT_W'(1);
    case ({accept, resp_valid})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Counter registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_q <= '0;
      cnt_q  <= '0;
    end else begin
      wait_q <= wait_d;
      cnt_q  <= cnt_d;
    end
  end

  cv32e40p_obi_resp_pipe #(
    .LATENCY (LAT)
  ) u_resp_pipe (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .push_i       (accept),
    .push_entry_i (push_entry),
    .mem_rdata_i  (mem_rdata_i),
    .valid_o      (resp_valid),
    .rdata_o      (obi_rdata_o),
    .err_o        (obi_err_o)
  );

  assign obi_rvalid_o = resp_valid;

endmodule
